codec_access_arbiter: RTL

//  N-channel arbiter for CODEC register RD/WR access; sits between requesters (init unit, AXI regs, DSP ctl) and i2c_seq_sm.

---
 rtl/codec_arb_pkg.sv | 18 +
 rtl/codec_rr_arbiter.sv | 40 ++++
 rtl/codec_access_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/codec_arb_pkg.sv
// Shared types for the CODEC register-access arbiter: FSM state encoding and
// arbitration-mode selectors.
package codec_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT_BSY,
    WAIT_DONE,
    CHECK,
    RESP
  } arb_state_t;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/codec_rr_arbiter.sv
// Combinational channel picker: round-robin from ptr_i, or fixed priority
// (lowest index wins) when ARB_MODE is ARB_FIXED.
module codec_rr_arbiter
  import codec_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ARB_MODE = ARB_RR,
  localparam int unsigned IdxW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] elig_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan candidates in priority order; the first eligible one wins.
  always_comb begin : p_pick
    logic [IdxW-1:0] cand;
    logic            found;
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = IdxW'(k);
      end else begin
        cand = IdxW'((32'(ptr_i) + k) % N_CH);
      end
      if (!found && elig_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/codec_access_arbiter.sv
// N-channel arbiter for CODEC register read/write access in front of i2c_seq_sm.
// Handles init lock-out, retry on missed ACK and per-channel error pulses.
// Optional watchdog: define CODEC_ARB_TIMEOUT_EN to abort stalled transfers
// after TMO_CYC cycles in any single wait state.
module codec_access_arbiter
  import codec_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned ARB_MODE  = ARB_RR,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TMO_CYC   = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init_lock,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH-1:0]    ch_we,
  input  logic [N_CH*AW-1:0] ch_addr,
  input  logic [N_CH*DW-1:0] ch_wdata,
  output logic [N_CH-1:0]    ch_ack,
  output logic [N_CH-1:0]    ch_err,
  output logic [DW-1:0]      ch_rdata,
  output logic               dn_rd_en,
  output logic               dn_wr_en,
  output logic [AW-1:0]      dn_addr,
  output logic [DW-1:0]      dn_wdata,
  input  logic [DW-1:0]      dn_rdata,
  input  logic               dn_rdata_valid,
  input  logic               dn_busy,
  input  logic               dn_missed_ack,
  output logic               busy
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_t       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d, win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [2:0]       retry_q, retry_d;
  logic [DW-1:0]    rd_lat_q, rd_lat_d;
  logic             rvalid_q, rvalid_d;
  logic             missed_q, missed_d;
  logic [N_CH-1:0]  ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]    ch_rdata_q, ch_rdata_d;

  logic [N_CH-1:0]  elig, gnt_oh;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic             resp_go, resp_err;
  logic             tmo_hit;

  // Lock-out leaves only the init channel (index 0) eligible.
  assign elig = init_lock ? (ch_req & N_CH'(1)) : ch_req;

  codec_rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_oh),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

`ifdef CODEC_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            waiting;
  assign waiting = (state_q == ISSUE) || (state_q == WAIT_BSY) || (state_q == WAIT_DONE);
  assign tmo_hit = waiting && (tmo_q == TmoW'(TMO_CYC - 1));
  // Watchdog restarts on every state change so each wait phase gets the full budget.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (waiting) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^(32'(TMO_CYC));
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and registered-output logic for the whole transfer FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    retry_d    = retry_q;
    rd_lat_d   = rd_lat_q;
    rvalid_d   = rvalid_q;
    missed_d   = missed_q;
    ack_d      = '0;
    err_d      = '0;
    ch_rdata_d = '0;
    resp_go    = 1'b0;
    resp_err   = 1'b0;
    unique case (state_q)
      IDLE: if (|elig) state_d = ARB;
      ARB: begin
        if (gnt_valid) begin
          win_d    = gnt_idx;
          we_d     = |(ch_we & gnt_oh);
          addr_d   = ch_addr[32'(gnt_idx) * AW +: AW];
          wdata_d  = ch_wdata[32'(gnt_idx) * DW +: DW];
          ptr_d    = (32'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + IdxW'(1);
          retry_d  = '0;
          rvalid_d = 1'b0;
          rd_lat_d = '0;
          missed_d = 1'b0;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:    if (!dn_busy) state_d = WAIT_BSY;
      WAIT_BSY: if (dn_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (dn_rdata_valid && !we_q) begin
          rd_lat_d = dn_rdata;
          rvalid_d = 1'b1;
        end
        if (!dn_busy) begin
          missed_d = dn_missed_ack;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (missed_q && (retry_q < 3'(MAX_RETRY))) begin
          retry_d  = retry_q + 3'd1;
          rvalid_d = 1'b0;
          state_d  = ISSUE;
        end else begin
          resp_go  = 1'b1;
          // A read that never delivered data is a failure even if ACKed.
          resp_err = missed_q | (!we_q & !rvalid_q);
        end
      end
      RESP: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      resp_go  = 1'b1;
      resp_err = 1'b1;
    end
    if (resp_go) begin
      state_d       = RESP;
      ack_d[win_q]  = 1'b1;
      err_d[win_q]  = resp_err;
      ch_rdata_d    = (we_q || resp_err) ? '0 : rd_lat_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      retry_q    <= '0;
      rd_lat_q   <= '0;
      rvalid_q   <= 1'b0;
      missed_q   <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      ch_rdata_q <= '0;
`ifdef CODEC_ARB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      retry_q    <= retry_d;
      rd_lat_q   <= rd_lat_d;
      rvalid_q   <= rvalid_d;
      missed_q   <= missed_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ch_rdata_q <= ch_rdata_d;
`ifdef CODEC_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Strobe fires in the single ISSUE cycle where the sequencer is free.
  assign dn_rd_en = (state_q == ISSUE) && !dn_busy && !tmo_hit && !we_q;
  assign dn_wr_en = (state_q == ISSUE) && !dn_busy && !tmo_hit && we_q;
  assign dn_addr  = addr_q;
  assign dn_wdata = wdata_q;
  assign ch_ack   = ack_q;
  assign ch_err   = err_q;
  assign ch_rdata = ch_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule
